vedic_2x2: RTL and testbench



---
 rtl/vedic_2x2_if.sv | 32 +++
 rtl/vedic_2x2.sv | 90 +++++++++
 tb/tb_vedic_2x2.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/vedic_2x2_if.sv
// ============================================================================
// Module   : vedic_2x2_if
// Brief    : Operand/product bus for the 2x2 Vedic multiplier leaf cell.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vedic_2x2_if;
    logic       in_valid;
    logic [1:0] a;
    logic [1:0] b;
    logic       out_valid;
    logic [3:0] c;

    modport master (
        output in_valid,
        output a,
        output b,
        input  out_valid,
        input  c
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        output out_valid,
        output c
    );
endinterface

`default_nettype wire

// File: rtl/vedic_2x2.sv
// ============================================================================
// Module   : vedic_2x2
// Brief    : Pipelined 2x2 unsigned Urdhva-Tiryagbhyam multiplier leaf cell.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vedic_half_adder (
    input  wire logic i_a,
    input  wire logic i_b,
    output logic      o_sum,
    output logic      o_carry
);
    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;
endmodule

module vedic_2x2 (
    input  wire logic   clk,
    input  wire logic   rst,
    vedic_2x2_if.slave  bus
);
    logic [1:0] r_a;
    logic [1:0] r_b;
    logic       r_v1;
    logic [3:0] r_c;
    logic       r_out_valid;

    logic       w_c0;
    logic       w_p1;
    logic       w_p2;
    logic       w_p3;
    logic       w_c1;
    logic       w_k;
    logic       w_c2;
    logic       w_c3;

    // Operand register: a/b hold across bubbles, only v1 tracks in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a  <= 2'b00;
            r_b  <= 2'b00;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_a <= bus.a;
                r_b <= bus.b;
            end
        end
    end

    // Vertical (a0b0, a1b1) and crosswise (a1b0, a0b1) partial products.
    assign w_c0 = r_a[0] & r_b[0];
    assign w_p1 = r_a[1] & r_b[0];
    assign w_p2 = r_a[0] & r_b[1];
    assign w_p3 = r_a[1] & r_b[1];

    vedic_half_adder u_ha1 (
        .i_a     (w_p1),
        .i_b     (w_p2),
        .o_sum   (w_c1),
        .o_carry (w_k)
    );

    vedic_half_adder u_ha2 (
        .i_a     (w_p3),
        .i_b     (w_k),
        .o_sum   (w_c2),
        .o_carry (w_c3)
    );

    // Product register holds its last value during bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c         <= 4'h0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_c <= {w_c3, w_c2, w_c1, w_c0};
            end
        end
    end

    assign bus.c         = r_c;
    assign bus.out_valid = r_out_valid;
endmodule

`default_nettype wire

// File: tb/tb_vedic_2x2.sv
// ============================================================================
// Module   : tb_vedic_2x2
// Brief    : Directed self-checking bench for the vedic_2x2 multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vedic_2x2;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    vedic_2x2_if bus_if ();

    vedic_2x2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [1:0] b);
        bus_if.in_valid = v;
        bus_if.a        = a;
        bus_if.b        = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 2'd3, 2'd3);
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (bus_if.c !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_c[%0d]: got %0h expected 0", i, bus_if.c);
            end
            n_tests++;
            if (bus_if.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid[%0d]: got %b expected 0", i, bus_if.out_valid);
            end
        end
        rst = 1'b0;
        drive(1'b0, 2'd3, 2'd3);
        step();
        n_tests++;
        if (bus_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_valid: got %b expected 0", bus_if.out_valid);
        end
    endtask

    // Pairs presented on consecutive edges; result of pair i is visible after
    // the second edge following its presentation.
    task automatic test_directed();
        logic [1:0] va [4];
        logic [1:0] vb [4];
        logic [3:0] ex [4];
        va = '{2'd1, 2'd2, 2'd3, 2'd3};
        vb = '{2'd2, 2'd2, 2'd2, 2'd3};
        ex = '{4'd2, 4'd4, 4'd6, 4'd9};
        for (int j = 0; j < 6; j++) begin
            if (j < 4) drive(1'b1, va[j], vb[j]);
            else       drive(1'b0, 2'd0, 2'd0);
            step();
            if (j == 0) begin
                n_tests++;
                if (bus_if.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL directed_early_valid: got %b expected 0", bus_if.out_valid);
                end
            end else if (j <= 4) begin
                n_tests++;
                if (bus_if.out_valid !== 1'b1 || bus_if.c !== ex[j-1]) begin
                    n_fail++;
                    $display("FAIL directed[%0d]: got valid=%b c=%0d expected valid=1 c=%0d",
                             j - 1, bus_if.out_valid, bus_if.c, ex[j-1]);
                end
            end else begin
                n_tests++;
                if (bus_if.out_valid !== 1'b0 || bus_if.c !== 4'd9) begin
                    n_fail++;
                    $display("FAIL directed_tail: got valid=%b c=%0d expected valid=0 c=9",
                             bus_if.out_valid, bus_if.c);
                end
            end
        end
    endtask

    task automatic test_exhaustive();
        // Row-major over a (outer) then b (inner): a*b.
        logic [3:0] ex [16];
        ex = '{4'd0, 4'd0, 4'd0, 4'd0,
               4'd0, 4'd1, 4'd2, 4'd3,
               4'd0, 4'd2, 4'd4, 4'd6,
               4'd0, 4'd3, 4'd6, 4'd9};
        for (int j = 0; j < 17; j++) begin
            if (j < 16) drive(1'b1, 2'(j / 4), 2'(j % 4));
            else        drive(1'b0, 2'd0, 2'd0);
            step();
            if (j >= 1) begin
                n_tests++;
                if (bus_if.out_valid !== 1'b1 || bus_if.c !== ex[j-1]) begin
                    n_fail++;
                    $display("FAIL exhaustive a=%0d b=%0d: got valid=%b c=%0d expected valid=1 c=%0d",
                             (j - 1) / 4, (j - 1) % 4, bus_if.out_valid, bus_if.c, ex[j-1]);
                end
            end
        end
        step();
        n_tests++;
        if (bus_if.out_valid !== 1'b0 || bus_if.c !== 4'd9) begin
            n_fail++;
            $display("FAIL exhaustive_tail: got valid=%b c=%0d expected valid=0 c=9",
                     bus_if.out_valid, bus_if.c);
        end
    endtask

    task automatic test_bubble();
        logic       exp_v [4];
        exp_v = '{1'b0, 1'b1, 1'b0, 1'b0};
        drive(1'b1, 2'd2, 2'd3);
        for (int j = 0; j < 4; j++) begin
            step();
            drive(1'b0, 2'(j + 1), 2'(3 - j));
            n_tests++;
            if (bus_if.out_valid !== exp_v[j] || (j > 0 && bus_if.c !== 4'd6)) begin
                n_fail++;
                $display("FAIL bubble[%0d]: got valid=%b c=%0d expected valid=%b c=6",
                         j, bus_if.out_valid, bus_if.c, exp_v[j]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 2'd3, 2'd3);
        step();
        rst = 1'b1;
        drive(1'b0, 2'd0, 2'd0);
        step();
        rst = 1'b0;
        for (int j = 0; j < 2; j++) begin
            n_tests++;
            if (bus_if.out_valid !== 1'b0 || bus_if.c !== 4'd0) begin
                n_fail++;
                $display("FAIL midflight_flush[%0d]: got valid=%b c=%0d expected valid=0 c=0",
                         j, bus_if.out_valid, bus_if.c);
            end
            step();
        end
        drive(1'b1, 2'd1, 2'd3);
        step();
        drive(1'b0, 2'd0, 2'd0);
        n_tests++;
        if (bus_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_early: got valid=%b expected 0", bus_if.out_valid);
        end
        step();
        n_tests++;
        if (bus_if.out_valid !== 1'b1 || bus_if.c !== 4'd3) begin
            n_fail++;
            $display("FAIL midflight_result: got valid=%b c=%0d expected valid=1 c=3",
                     bus_if.out_valid, bus_if.c);
        end
        step();
        n_tests++;
        if (bus_if.out_valid !== 1'b0 || bus_if.c !== 4'd3) begin
            n_fail++;
            $display("FAIL midflight_hold: got valid=%b c=%0d expected valid=0 c=3",
                     bus_if.out_valid, bus_if.c);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        drive(1'b0, 2'd0, 2'd0);
        #2;
        test_reset();
        test_directed();
        test_exhaustive();
        test_bubble();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
